// File: rtl/apb_mem_slave.sv
// APB4 word-addressed memory slave with byte strobes, a read-only low region and range/alignment errors.
// Latency: pready rises WAIT_STATES+1 cycles after the setup cycle; prdata/pslverr are registered and valid alongside it.
// Backpressure: wait states are held by keeping pready low; dropping psel/penable mid-transfer aborts it with no write.
module apb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int RO_WORDS    = 0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int SW = DATA_W / 8;
  localparam int AL = $clog2(SW);
  localparam int IW = $clog2(DEPTH);
  // Byte-offset bits inside a word; all-zero for an 8-bit bus, so the alignment check vanishes there.
  localparam logic [ADDR_W-1:0] AL_MASK   = ADDR_W'((1 << AL) - 1);
  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [IW-1:0]       idx_q;
  logic                wr_q;
  logic                err_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [SW-1:0]       strb_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Setup-phase decode on the live address; the full-width index is compared so high bits never alias.
  logic [ADDR_W-1:0]   idx_full;
  logic                misalign;
  logic                range_err;
  logic                ro_err;
  logic                setup_err;
  logic                setup;
  logic                access;
  logic                mem_we;

  assign idx_full  = paddr >> AL;
  assign misalign  = |(paddr & AL_MASK);
  assign range_err = (idx_full >= DEPTH_LIM);
  assign setup_err = misalign | range_err | ro_err;
  assign setup     = psel & ~penable;
  assign access    = psel & penable;

  generate
    if (RO_WORDS > 0) begin : g_ro
      localparam logic [ADDR_W-1:0] RO_LIM = ADDR_W'(RO_WORDS);
      assign ro_err = pwrite & (idx_full < RO_LIM);
    end else begin : g_no_ro
      assign ro_err = 1'b0;
    end
  endgenerate

  // Writes land on the completing RESP edge only; an abort or reset in that cycle suppresses them.
  assign mem_we = (state == S_RESP) & access & wr_q & ~err_q & ~preset;

  // Transfer FSM: capture at setup, count wait states, present one registered response cycle.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (setup) begin
            idx_q   <= idx_full[IW-1:0];
            wr_q    <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            err_q   <= setup_err;
            if (WAIT_STATES == 0) begin
              state   <= S_RESP;
              pready  <= 1'b1;
              pslverr <= setup_err;
              prdata  <= (pwrite || setup_err) ? '0 : mem[idx_full[IW-1:0]];
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          if (access) begin
            if (cnt == 4'd1) begin
              state   <= S_RESP;
              cnt     <= 4'd0;
              pready  <= 1'b1;
              pslverr <= err_q;
              prdata  <= (wr_q || err_q) ? '0 : mem[idx_q];
            end else begin
              cnt <= cnt - 4'd1;
            end
          end else begin
            // Master let go (or restarted with a new setup): drop the transfer.
            state   <= S_IDLE;
            cnt     <= 4'd0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
          end
        end
        S_RESP: begin
          // Completed or aborted, the response lasts exactly one cycle.
          state   <= S_IDLE;
          prdata  <= '0;
          pready  <= 1'b0;
          pslverr <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= 4'd0;
          prdata  <= '0;
          pready  <= 1'b0;
          pslverr <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane write into the array; contents survive reset.
  always_ff @(posedge pclk) begin
    if (mem_we) begin
      for (int b = 0; b < SW; b++) begin
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: five differently parameterised instances share one APB master, selected by psel.
// A word-array model per instance predicts latency, pslverr and prdata from the address/strobe rules.
// Directed cases cover strobes, errors, wait states, abort and reset; a random phase follows.
module tb_apb_mem_slave;

  localparam int N = 5;

  int dw_a    [N] = '{32, 32, 32, 8, 64};
  int depth_a [N] = '{16, 16, 16, 4, 4};
  int ws_a    [N] = '{0, 2, 3, 0, 1};
  int ro_a    [N] = '{0, 2, 0, 0, 0};

  logic        pclk = 1'b0;
  logic        preset;
  logic [31:0] paddr;
  logic [4:0]  psel_v;
  logic        penable;
  logic        pwrite;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;

  logic [31:0] prd0, prd1, prd2;
  logic [7:0]  prd3;
  logic [63:0] prd4;
  logic [4:0]  prdy, perr;

  int n_chk, n_pass;

  logic [63:0] mm [N][16];
  bit          kn [N][16];

  logic [63:0] r_d;
  logic        r_e;

  always #5 pclk = ~pclk;

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_STATES(0), .RO_WORDS(0)) u0 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel_v[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]),
    .prdata(prd0), .pready(prdy[0]), .pslverr(perr[0]));

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_STATES(2), .RO_WORDS(2)) u1 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel_v[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]),
    .prdata(prd1), .pready(prdy[1]), .pslverr(perr[1]));

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_STATES(3), .RO_WORDS(0)) u2 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel_v[2]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]),
    .prdata(prd2), .pready(prdy[2]), .pslverr(perr[2]));

  apb_mem_slave #(.DATA_W(8), .ADDR_W(32), .DEPTH(4), .WAIT_STATES(0), .RO_WORDS(0)) u3 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel_v[3]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata[7:0]), .pstrb(pstrb[0:0]),
    .prdata(prd3), .pready(prdy[3]), .pslverr(perr[3]));

  apb_mem_slave #(.DATA_W(64), .ADDR_W(32), .DEPTH(4), .WAIT_STATES(1), .RO_WORDS(0)) u4 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel_v[4]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prd4), .pready(prdy[4]), .pslverr(perr[4]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] rd_of(input int i);
    case (i)
      0:       return {32'b0, prd0};
      1:       return {32'b0, prd1};
      2:       return {32'b0, prd2};
      3:       return {56'b0, prd3};
      default: return prd4;
    endcase
  endfunction

  function automatic int al_of(input int i);
    case (dw_a[i])
      8:       return 0;
      16:      return 1;
      32:      return 2;
      default: return 3;
    endcase
  endfunction

  // Error rule: misaligned byte offset, word index past the array, or a write into the protected low words.
  function automatic bit exp_err(input int i, input logic [31:0] a, input bit wr);
    logic [31:0] idx;
    int al;
    al  = al_of(i);
    idx = a >> al;
    if (al > 0 && (a & ((32'd1 << al) - 32'd1)) != 32'd0) return 1'b1;
    if (idx >= 32'(depth_a[i])) return 1'b1;
    if (wr && idx < 32'(ro_a[i])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_addr(input int i);
    logic [31:0] idx;
    int al;
    al  = al_of(i);
    idx = 32'($urandom_range(0, depth_a[i] - 1));
    case ($urandom_range(0, 5))
      3:       return (al > 0) ? ((idx << al) | 32'($urandom_range(1, (1 << al) - 1))) : idx;
      4:       return (idx + 32'(depth_a[i])) << al;
      5:       return 32'h8000_0000 | (idx << al);
      default: return idx << al;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pclk);
      psel_v  = '0;
      penable = 1'b0;
    end
  endtask

  // One complete APB transfer to instance i; checks completion latency and response against the model.
  task automatic xfer(input int i, input logic [31:0] a, input bit wr, input logic [63:0] wd,
                      input logic [7:0] sb, output logic [63:0] rd, output logic er);
    bit ee;
    int idx;
    int lat;
    ee  = exp_err(i, a, wr);
    idx = ee ? 0 : int'(a >> al_of(i));
    @(negedge pclk);
    paddr   = a;
    pwrite  = wr;
    pwdata  = wd;
    pstrb   = sb;
    psel_v  = 5'(1 << i);
    penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (prdy[i]) begin
        lat = c;
        break;
      end
      @(negedge pclk);
    end
    chk("latency", 64'(lat), 64'(ws_a[i] + 1));
    rd = rd_of(i);
    er = perr[i];
    if (lat == 0) return;
    chk("pslverr", 64'(er), 64'(ee));
    if (wr || ee) chk("prdata_zero", rd, 64'd0);
    else if (kn[i][idx]) chk("prdata", rd, mm[i][idx]);
    else begin
      // Protected words are never written, so their first read defines what later reads must repeat.
      mm[i][idx] = rd;
      kn[i][idx] = 1'b1;
    end
    if (wr && !ee) begin
      for (int b = 0; b < dw_a[i] / 8; b++)
        if (sb[b]) mm[i][idx][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    preset  = 1'b1;
    psel_v  = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    for (int i = 0; i < N; i++)
      for (int w = 0; w < 16; w++) begin
        mm[i][w] = '0;
        kn[i][w] = 1'b0;
      end

    repeat (3) @(negedge pclk);
    for (int i = 0; i < N; i++) begin
      chk("rst_pready", 64'(prdy[i]), 64'd0);
      chk("rst_pslverr", 64'(perr[i]), 64'd0);
      chk("rst_prdata", rd_of(i), 64'd0);
    end
    preset = 1'b0;

    // Give every writable word a known value.
    for (int i = 0; i < N; i++)
      for (int w = ro_a[i]; w < depth_a[i]; w++) begin
        xfer(i, 32'(w) << al_of(i), 1'b1, {$urandom, $urandom}, 8'hFF, r_d, r_e);
        kn[i][w] = 1'b1;
      end
    idle(2);

    // 32-bit, no wait states: full write, byte strobes, empty strobe, errors.
    xfer(0, 32'h08, 1'b1, 64'hDEAD_BEEF, 8'hF, r_d, r_e);
    chk("u0_wr_err", 64'(r_e), 64'd0);
    xfer(0, 32'h08, 1'b0, 64'd0, 8'h0, r_d, r_e);
    chk("u0_rd_deadbeef", r_d, 64'hDEAD_BEEF);
    xfer(0, 32'h08, 1'b1, 64'h1122_3344, 8'h5, r_d, r_e);
    xfer(0, 32'h08, 1'b0, 64'd0, 8'h0, r_d, r_e);
    chk("u0_rd_strb5", r_d, 64'hDE22_BE44);
    xfer(0, 32'h08, 1'b1, 64'hFFFF_FFFF, 8'h0, r_d, r_e);
    chk("u0_strb0_err", 64'(r_e), 64'd0);
    xfer(0, 32'h08, 1'b0, 64'd0, 8'h0, r_d, r_e);
    chk("u0_rd_strb0", r_d, 64'hDE22_BE44);
    xfer(0, 32'h40, 1'b0, 64'd0, 8'h0, r_d, r_e);
    chk("u0_oor_err", 64'(r_e), 64'd1);
    chk("u0_oor_data", r_d, 64'd0);
    xfer(0, 32'h00, 1'b1, 64'h0BAD_F00D, 8'hF, r_d, r_e);
    xfer(0, 32'h0000_0402, 1'b1, 64'h5555_5555, 8'hF, r_d, r_e);
    chk("u0_misal_err", 64'(r_e), 64'd1);
    xfer(0, 32'h00, 1'b0, 64'd0, 8'h0, r_d, r_e);
    chk("u0_misal_nowr", r_d, 64'h0BAD_F00D);
    idle(1);

    // Two wait states, read-only low words, back-to-back transfers.
    xfer(1, 32'h04, 1'b0, 64'd0, 8'h0, r_d, r_e);
    xfer(1, 32'h04, 1'b1, 64'hAAAA_5555, 8'hF, r_d, r_e);
    chk("u1_ro_err", 64'(r_e), 64'd1);
    xfer(1, 32'h04, 1'b0, 64'd0, 8'h0, r_d, r_e);
    xfer(1, 32'h10, 1'b0, 64'd0, 8'h0, r_d, r_e);
    xfer(1, 32'h14, 1'b1, 64'hCAFE_F00D, 8'hF, r_d, r_e);
    xfer(1, 32'h14, 1'b0, 64'd0, 8'h0, r_d, r_e);
    chk("u1_b2b_rd", r_d, 64'hCAFE_F00D);
    idle(1);

    // Three wait states: abort by dropping psel in the second wait cycle.
    @(negedge pclk);
    paddr = 32'h0C; pwrite = 1'b1; pwdata = 64'h1234_5678; pstrb = 8'hF;
    psel_v = 5'b00100; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    chk("abort_c1", 64'(prdy[2]), 64'd0);
    @(negedge pclk);
    chk("abort_c2", 64'(prdy[2]), 64'd0);
    psel_v = '0;
    penable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk);
      chk("abort_no_pready", 64'(prdy[2]), 64'd0);
    end
    xfer(2, 32'h0C, 1'b0, 64'd0, 8'h0, r_d, r_e);

    // Reset while waiting: outputs clear, no write, next transfer completes normally.
    @(negedge pclk);
    paddr = 32'h0C; pwrite = 1'b1; pwdata = 64'h8765_4321; pstrb = 8'hF;
    psel_v = 5'b00100; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    chk("rst_mid_pready", 64'(prdy[2]), 64'd0);
    chk("rst_mid_pslverr", 64'(perr[2]), 64'd0);
    chk("rst_mid_prdata", rd_of(2), 64'd0);
    preset = 1'b0;
    psel_v = '0;
    penable = 1'b0;
    xfer(2, 32'h0C, 1'b0, 64'd0, 8'h0, r_d, r_e);
    xfer(2, 32'h0C, 1'b1, 64'h0F0F_0F0F, 8'hF, r_d, r_e);
    xfer(2, 32'h0C, 1'b0, 64'd0, 8'h0, r_d, r_e);
    chk("rst_after_wr", r_d, 64'h0F0F_0F0F);
    idle(1);

    // 8-bit bus, depth 4.
    xfer(3, 32'h3, 1'b1, 64'hA5, 8'h1, r_d, r_e);
    xfer(3, 32'h3, 1'b0, 64'd0, 8'h0, r_d, r_e);
    chk("u3_rd", r_d, 64'hA5);
    xfer(3, 32'h4, 1'b0, 64'd0, 8'h0, r_d, r_e);
    chk("u3_oor_err", 64'(r_e), 64'd1);
    xfer(3, 32'h103, 1'b1, 64'h3C, 8'h1, r_d, r_e);
    chk("u3_wrap_err", 64'(r_e), 64'd1);
    xfer(3, 32'h3, 1'b0, 64'd0, 8'h0, r_d, r_e);
    chk("u3_no_alias", r_d, 64'hA5);

    // 64-bit bus, depth 4, one wait state.
    xfer(4, 32'h18, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, r_d, r_e);
    xfer(4, 32'h18, 1'b0, 64'd0, 8'h0, r_d, r_e);
    chk("u4_rd", r_d, 64'h0123_4567_89AB_CDEF);
    xfer(4, 32'h20, 1'b0, 64'd0, 8'h0, r_d, r_e);
    chk("u4_oor_err", 64'(r_e), 64'd1);
    xfer(4, 32'h1C, 1'b1, 64'd0, 8'hFF, r_d, r_e);
    chk("u4_misal_err", 64'(r_e), 64'd1);
    xfer(4, 32'h8000_0018, 1'b1, 64'd0, 8'hFF, r_d, r_e);
    chk("u4_wrap_err", 64'(r_e), 64'd1);
    xfer(4, 32'h18, 1'b0, 64'd0, 8'h0, r_d, r_e);
    chk("u4_no_alias", r_d, 64'h0123_4567_89AB_CDEF);
    idle(1);

    // Random traffic on every instance, mixing back-to-back and gapped transfers.
    for (int i = 0; i < N; i++) begin
      repeat (40) begin
        xfer(i, rand_addr(i), 1'($urandom_range(0, 1)), {$urandom, $urandom},
             8'($urandom_range(0, 255)), r_d, r_e);
        if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(1);
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
